tlb: RTL and testbench

TLB -- requirements
Module: tlb

---
 rtl/tlb_if.sv | 49 ++++
 rtl/tlb.sv | 85 ++++++++
 tb/tb_tlb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tlb_if.sv
// tlb_if: search, invalidate, write and read signal bundle between mmu and tlb
interface tlb_if;
   logic [18:0] s0_vppn, s1_vppn;
   logic        s0_va_bit12, s1_va_bit12;
   logic [9:0]  s0_asid, s1_asid;
   logic        s0_found, s1_found;
   logic [3:0]  s0_index, s1_index;
   logic [19:0] s0_ppn, s1_ppn;
   logic [5:0]  s0_ps, s1_ps;
   logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
   logic        s0_d, s1_d, s0_v, s1_v;
   logic        invtlb_valid;
   logic [4:0]  invtlb_op;
   logic        we;
   logic [3:0]  w_index;
   logic        w_e, w_g;
   logic [18:0] w_vppn;
   logic [5:0]  w_ps;
   logic [9:0]  w_asid;
   logic [19:0] w_ppn0, w_ppn1;
   logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;
   logic        w_d0, w_d1, w_v0, w_v1;
   logic [3:0]  r_index;
   logic        r_e, r_g;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
   logic        r_d0, r_d1, r_v0, r_v1;
   modport master (
      output s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
             invtlb_valid, invtlb_op, we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
             w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1, r_index,
      input  s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
             s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
             r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
             r_ppn1, r_plv1, r_mat1, r_d1, r_v1
   );
   modport slave (
      input  s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
             invtlb_valid, invtlb_op, we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
             w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1, r_index,
      output s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
             s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
             r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
             r_ppn1, r_plv1, r_mat1, r_d1, r_v1
   );
endinterface

// File: rtl/tlb.sv
// tlb: 16-entry dual-port search TLB with write, read and INVTLB invalidation
module tlb (
   input logic  clk,
   input logic  resetn,
   tlb_if.slave bus
);
   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0, mat0;
      logic        d0, v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1, mat1;
      logic        d1, v1;
   } entry_t;
   typedef struct packed {
      logic        found;
      logic [3:0]  index;
      logic [19:0] ppn;
      logic [5:0]  ps;
      logic [1:0]  plv, mat;
      logic        d, v;
   } res_t;
   entry_t [15:0] tlb_q, tlb_d;
   entry_t        r_ent;
   res_t          s0_res, s1_res;
   function automatic logic va_hit(entry_t t, logic [18:0] vppn);
      return t.ps == 6'd21 ? t.vppn[18:9] == vppn[18:9] : t.vppn == vppn;
   endfunction
   function automatic res_t lookup(entry_t [15:0] t, logic [18:0] vppn, logic bit12, logic [9:0] asid);
      res_t r;
      logic odd;
      r = '0;
      // descending scan so the lowest matching index is the one left in r
      for (int i = 15; i >= 0; i--) begin
         if (t[i].e && (t[i].g || t[i].asid == asid) && va_hit(t[i], vppn)) begin
            odd = t[i].ps == 6'd21 ? vppn[8] : bit12;
            r.found = 1'b1;
            r.index = 4'(i);
            r.ps = t[i].ps;
            {r.ppn, r.plv, r.mat, r.d, r.v} = odd ? {t[i].ppn1, t[i].plv1, t[i].mat1, t[i].d1, t[i].v1}
                                                  : {t[i].ppn0, t[i].plv0, t[i].mat0, t[i].d0, t[i].v0};
         end
      end
      return r;
   endfunction
   function automatic logic inv_hit(entry_t t, logic [4:0] op, logic [9:0] asid, logic [18:0] vppn);
      logic am, va;
      am = t.asid == asid;
      va = va_hit(t, vppn);
      return op < 5'd2  ? 1'b1 :
             op == 5'd2 ? t.g :
             op == 5'd3 ? !t.g :
             op == 5'd4 ? !t.g && am :
             op == 5'd5 ? !t.g && am && va :
             op == 5'd6 ? (t.g || am) && va : 1'b0;
   endfunction
   always_comb begin
      tlb_d = tlb_q;
      for (int i = 0; i < 16; i++)
         if (bus.invtlb_valid && inv_hit(tlb_q[i], bus.invtlb_op, bus.s1_asid, bus.s1_vppn)) tlb_d[i].e = 1'b0;
      // the write lands after invalidation so it wins on its own entry
      if (bus.we) tlb_d[bus.w_index] = '{bus.w_e, bus.w_vppn, bus.w_ps, bus.w_asid, bus.w_g,
                                         bus.w_ppn0, bus.w_plv0, bus.w_mat0, bus.w_d0, bus.w_v0,
                                         bus.w_ppn1, bus.w_plv1, bus.w_mat1, bus.w_d1, bus.w_v1};
   end
   always_ff @(posedge clk) begin
      if (!resetn) tlb_q <= '0;
      else tlb_q <= tlb_d;
   end
   always_comb begin
      s0_res = lookup(tlb_q, bus.s0_vppn, bus.s0_va_bit12, bus.s0_asid);
      s1_res = lookup(tlb_q, bus.s1_vppn, bus.s1_va_bit12, bus.s1_asid);
      r_ent = tlb_q[bus.r_index];
   end
   assign {bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_ps, bus.s0_plv, bus.s0_mat, bus.s0_d, bus.s0_v} = s0_res;
   assign {bus.s1_found, bus.s1_index, bus.s1_ppn, bus.s1_ps, bus.s1_plv, bus.s1_mat, bus.s1_d, bus.s1_v} = s1_res;
   assign {bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g,
           bus.r_ppn0, bus.r_plv0, bus.r_mat0, bus.r_d0, bus.r_v0,
           bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1, bus.r_v1} = r_ent;
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: vector table plus multi-cycle sequences, search results checked through a scoreboard queue
module tb_tlb;
   logic clk = 1'b0;
   logic resetn;
   tlb_if bus();
   tlb dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   localparam logic [36:0] miss = '0;
   typedef struct { int port; logic [36:0] exp; int tag; } sb_t;
   typedef struct {
      logic [18:0] v0; logic b0; logic [9:0] a0; logic [36:0] e0;
      logic [18:0] v1; logic b1; logic [9:0] a1; logic [36:0] e1;
   } vec_t;
   sb_t sb[$];
   vec_t vecs[6];
   int vectors = 0, miscompares = 0, tag = 0;
   string phase = "reset";
   logic [36:0] s0_act, s1_act;
   logic [56:0] r_act;
   assign s0_act = {bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_ps, bus.s0_plv, bus.s0_mat, bus.s0_d, bus.s0_v};
   assign s1_act = {bus.s1_found, bus.s1_index, bus.s1_ppn, bus.s1_ps, bus.s1_plv, bus.s1_mat, bus.s1_d, bus.s1_v};
   assign r_act = {bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g, bus.r_ppn0};
   // every written entry uses fixed page attributes: page0 plv1/mat1/d1/v1, page1 plv2/mat2/d0/v1
   function automatic logic [36:0] hit(int idx, logic [19:0] ppn, logic [5:0] ps, bit odd);
      return odd ? {1'b1, 4'(idx), ppn, ps, 2'd2, 2'd2, 1'b0, 1'b1}
                 : {1'b1, 4'(idx), ppn, ps, 2'd1, 2'd1, 1'b1, 1'b1};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      bus.invtlb_valid = 1'b0;
   endtask
   task automatic drive(int port, logic [18:0] vppn, logic b12, logic [9:0] asid, logic [36:0] exp);
      if (port == 0) begin
         bus.s0_vppn = vppn; bus.s0_va_bit12 = b12; bus.s0_asid = asid;
      end else begin
         bus.s1_vppn = vppn; bus.s1_va_bit12 = b12; bus.s1_asid = asid;
      end
      sb.push_back('{port, exp, tag});
      tag++;
   endtask
   task automatic settle();
      sb_t x;
      logic [36:0] act;
      @(negedge clk);
      while (sb.size() > 0) begin
         x = sb.pop_front();
         act = x.port == 0 ? s0_act : s1_act;
         vectors++;
         if (act !== x.exp) begin
            miscompares++;
            $display("FAIL %s search#%0d port%0d got %h want %h", phase, x.tag, x.port, act, x.exp);
         end
      end
   endtask
   task automatic srch(int port, logic [18:0] vppn, logic b12, logic [9:0] asid, logic [36:0] exp);
      drive(port, vppn, b12, asid, exp);
      settle();
   endtask
   task automatic rd(int idx, logic e, logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid, logic g, logic [19:0] ppn0);
      bus.r_index = 4'(idx);
      @(negedge clk);
      vectors++;
      if (r_act !== {e, vppn, ps, asid, g, ppn0}) begin
         miscompares++;
         $display("FAIL %s read idx%0d got %h want %h", phase, idx, r_act, {e, vppn, ps, asid, g, ppn0});
      end
   endtask
   task automatic set_w(int idx, logic e, logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid, logic g,
                        logic [19:0] p0, logic [19:0] p1);
      bus.we = 1'b1; bus.w_index = 4'(idx); bus.w_e = e; bus.w_vppn = vppn; bus.w_ps = ps;
      bus.w_asid = asid; bus.w_g = g; bus.w_ppn0 = p0; bus.w_ppn1 = p1;
      bus.w_plv0 = 2'd1; bus.w_mat0 = 2'd1; bus.w_d0 = 1'b1; bus.w_v0 = 1'b1;
      bus.w_plv1 = 2'd2; bus.w_mat1 = 2'd2; bus.w_d1 = 1'b0; bus.w_v1 = 1'b1;
   endtask
   task automatic wr(int idx, logic e, logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid, logic g,
                     logic [19:0] p0, logic [19:0] p1);
      set_w(idx, e, vppn, ps, asid, g, p0, p1);
      step();
   endtask
   task automatic inv(int op, logic [9:0] asid, logic [18:0] vppn);
      bus.invtlb_valid = 1'b1; bus.invtlb_op = 5'(op); bus.s1_asid = asid; bus.s1_vppn = vppn;
      step();
   endtask
   initial begin
      resetn = 1'b0;
      bus.s0_vppn = '0; bus.s0_va_bit12 = 1'b0; bus.s0_asid = '0;
      bus.s1_vppn = '0; bus.s1_va_bit12 = 1'b0; bus.s1_asid = '0;
      bus.invtlb_valid = 1'b0; bus.invtlb_op = '0; bus.r_index = '0;
      set_w(0, 1'b1, 19'h0, 6'd12, 10'd0, 1'b1, 20'h1, 20'h2);
      step();
      step();
      srch(0, 19'h0, 1'b0, 10'd0, miss);
      srch(1, 19'h0, 1'b1, 10'd0, miss);
      rd(0, 1'b0, '0, '0, '0, 1'b0, '0);
      resetn = 1'b1;
      step();
      rd(15, 1'b0, '0, '0, '0, 1'b0, '0);
      phase = "table";
      wr(3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h12345, 20'h54321);
      wr(7, 1'b1, 19'h1FE00, 6'd21, 10'd9, 1'b1, 20'h0AAAA, 20'h0BBBB);
      vecs[0] = '{19'h00010, 1'b1, 10'd5, hit(3, 20'h54321, 6'd12, 1), 19'h00010, 1'b0, 10'd5, hit(3, 20'h12345, 6'd12, 0)};
      vecs[1] = '{19'h00010, 1'b1, 10'd6, miss, 19'h1FEFF, 1'b1, 10'h3FF, hit(7, 20'h0AAAA, 6'd21, 0)};
      vecs[2] = '{19'h1FF00, 1'b0, 10'd0, hit(7, 20'h0BBBB, 6'd21, 1), 19'h1FC00, 1'b0, 10'd9, miss};
      vecs[3] = '{19'h00011, 1'b0, 10'd5, miss, 19'h1FFFF, 1'b0, 10'd9, hit(7, 20'h0BBBB, 6'd21, 1)};
      vecs[4] = '{19'h00010, 1'b0, 10'd9, miss, 19'h00010, 1'b1, 10'd5, hit(3, 20'h54321, 6'd12, 1)};
      vecs[5] = '{19'h1FE00, 1'b1, 10'd1, hit(7, 20'h0AAAA, 6'd21, 0), 19'h00010, 1'b1, 10'd6, miss};
      foreach (vecs[i]) begin
         drive(0, vecs[i].v0, vecs[i].b0, vecs[i].a0, vecs[i].e0);
         drive(1, vecs[i].v1, vecs[i].b1, vecs[i].a1, vecs[i].e1);
         settle();
      end
      rd(3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h12345);
      rd(7, 1'b1, 19'h1FE00, 6'd21, 10'd9, 1'b1, 20'h0AAAA);
      phase = "priority";
      wr(2, 1'b1, 19'h00200, 6'd12, 10'd7, 1'b0, 20'h00002, 20'h10002);
      wr(9, 1'b1, 19'h00200, 6'd12, 10'd8, 1'b1, 20'h00009, 20'h10009);
      srch(0, 19'h00200, 1'b0, 10'd7, hit(2, 20'h00002, 6'd12, 0));
      inv(5, 10'd7, 19'h00200);
      srch(0, 19'h00200, 1'b0, 10'd7, hit(9, 20'h00009, 6'd12, 0));
      rd(2, 1'b0, 19'h00200, 6'd12, 10'd7, 1'b0, 20'h00002);
      phase = "invtlb";
      inv(0, 10'd0, 19'h0);
      srch(0, 19'h00010, 1'b1, 10'd5, miss);
      for (int i = 0; i < 8; i++)
         wr(i, 1'b1, 19'(32'h100 + i), 6'd12, i < 4 ? 10'd1 : 10'd5, i < 4, 20'(32'h100 + i), 20'(32'h200 + i));
      inv(2, 10'd0, 19'h0);
      for (int i = 0; i < 8; i++)
         srch(0, 19'(32'h100 + i), 1'b0, 10'd5, i < 4 ? miss : hit(i, 20'(32'h100 + i), 6'd12, 0));
      wr(8, 1'b1, 19'h108, 6'd12, 10'd6, 1'b0, 20'h00108, 20'h00208);
      inv(4, 10'd5, 19'h0);
      for (int i = 4; i < 8; i++) srch(1, 19'(32'h100 + i), 1'b0, 10'd5, miss);
      srch(0, 19'h108, 1'b0, 10'd6, hit(8, 20'h00108, 6'd12, 0));
      inv(0, 10'd0, 19'h0);
      rd(5, 1'b0, 19'h105, 6'd12, 10'd5, 1'b0, 20'h00105);
      phase = "same_cycle";
      wr(0, 1'b1, 19'h300, 6'd12, 10'd2, 1'b0, 20'h30000, 20'h30001);
      wr(1, 1'b1, 19'h301, 6'd12, 10'd2, 1'b0, 20'h11111, 20'h00001);
      set_w(1, 1'b1, 19'h301, 6'd12, 10'd2, 1'b0, 20'h22222, 20'h00002);
      srch(0, 19'h301, 1'b0, 10'd2, hit(1, 20'h11111, 6'd12, 0));
      step();
      srch(0, 19'h301, 1'b0, 10'd2, hit(1, 20'h22222, 6'd12, 0));
      set_w(1, 1'b1, 19'h301, 6'd12, 10'd2, 1'b0, 20'h33333, 20'h00003);
      bus.invtlb_valid = 1'b1; bus.invtlb_op = 5'd0;
      step();
      srch(0, 19'h300, 1'b0, 10'd2, miss);
      rd(0, 1'b0, 19'h300, 6'd12, 10'd2, 1'b0, 20'h30000);
      srch(0, 19'h301, 1'b0, 10'd2, hit(1, 20'h33333, 6'd12, 0));
      phase = "reset_write";
      wr(4, 1'b1, 19'h400, 6'd12, 10'd3, 1'b0, 20'h40000, 20'h50000);
      resetn = 1'b0;
      set_w(4, 1'b1, 19'h444, 6'd12, 10'd3, 1'b0, 20'h44444, 20'h55555);
      step();
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) rd(i, 1'b0, '0, '0, '0, 1'b0, '0);
      srch(0, 19'h444, 1'b0, 10'd3, miss);
      srch(1, 19'h301, 1'b0, 10'd2, miss);
      phase = "full_tlb";
      for (int i = 0; i < 16; i++)
         wr(i, 1'b1, 19'(32'h400 + i), 6'd12, 10'd3, 1'b0, 20'(32'h40000 + i), 20'(32'h50000 + i));
      inv(7, 10'd3, 19'h405);
      for (int i = 0; i < 16; i++) srch(0, 19'(32'h400 + i), 1'b0, 10'd3, hit(i, 20'(32'h40000 + i), 6'd12, 0));
      inv(6, 10'd3, 19'h405);
      srch(0, 19'h405, 1'b0, 10'd3, miss);
      srch(0, 19'h404, 1'b0, 10'd3, hit(4, 20'h40004, 6'd12, 0));
      inv(3, 10'd0, 19'h0);
      srch(0, 19'h404, 1'b0, 10'd3, miss);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
